// File: rtl/filter_seq_pkg.sv
// Shared types and default sizes for the filter step-response sequencer.
package filter_seq_pkg;

    localparam int DEF_WIDTH = 18;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_STEP   = 2'd2,
        ST_CHECK  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/seq_peak_track.sv
// Signed running maximum/minimum tracker; load overrides both with the current sample.
module seq_peak_track
    import filter_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] sample,
    output logic signed [WIDTH-1:0] peak_max,
    output logic signed [WIDTH-1:0] peak_min
);

    logic signed [WIDTH-1:0] max_q, max_d;
    logic signed [WIDTH-1:0] min_q, min_d;

    always_comb begin
        max_d = max_q;
        min_d = min_q;
        if (load) begin
            max_d = sample;
            min_d = sample;
        end else if (en) begin
            if (sample > max_q) max_d = sample;
            if (sample < min_q) min_d = sample;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            max_q <= '0;
            min_q <= '0;
        end else begin
            max_q <= max_d;
            min_q <= min_d;
        end
    end

    assign peak_max = max_q;
    assign peak_min = min_q;

endmodule

// File: rtl/filter_step_seq.sv
// Step-response sequencer: holds the filter input at zero, applies a step, then
// checks the final output against a target window and reports the output peaks.
module filter_step_seq
    import filter_seq_pkg::*;
#(
    parameter int                      WIDTH    = DEF_WIDTH,
    parameter int                      CNT_W    = DEF_CNT_W,
    parameter logic signed [WIDTH-1:0] STEP_VAL = 18'sd1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CNT_W-1:0]        settle_cycles,
    input  logic [CNT_W-1:0]        run_cycles,
    input  logic signed [WIDTH-1:0] target,
    input  logic [WIDTH-1:0]        tol,
    input  logic signed [WIDTH-1:0] v_out,
    output logic signed [WIDTH-1:0] v_in,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic signed [WIDTH-1:0] v_max,
    output logic signed [WIDTH-1:0] v_min
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    seq_state_t state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        settle_q, settle_d;
    logic [CNT_W-1:0]        run_q, run_d;
    logic signed [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0]        tol_q, tol_d;
    logic                    pass_q, pass_d;

    logic                    settle_last;
    logic                    step_last;
    logic signed [WIDTH:0]   diff;
    logic [WIDTH:0]          abs_diff;
    logic                    pass_now;
    logic                    peak_load;
    logic                    peak_en;

    // A zero count still spends one cycle in the phase; comparing against
    // latched-1 means the counter stops short of the terminal value and never wraps.
    assign settle_last = (settle_q == '0) || (cnt_q == settle_q - CNT_ONE);
    assign step_last   = (run_q == '0)    || (cnt_q == run_q - CNT_ONE);

    always_comb begin
        diff     = $signed({v_out[WIDTH-1], v_out}) - $signed({target_q[WIDTH-1], target_q});
        abs_diff = diff[WIDTH] ? $unsigned(-diff) : $unsigned(diff);
        pass_now = (abs_diff <= {1'b0, tol_q});
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        settle_d = settle_q;
        run_d    = run_q;
        target_d = target_q;
        tol_d    = tol_q;
        pass_d   = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    settle_d = settle_cycles;
                    run_d    = run_cycles;
                    target_d = target;
                    tol_d    = tol;
                    cnt_d    = '0;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_last) begin
                    cnt_d   = '0;
                    state_d = ST_STEP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_STEP: begin
                if (step_last) begin
                    cnt_d   = '0;
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_CHECK: begin
                pass_d  = pass_now;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            settle_q <= '0;
            run_q    <= '0;
            target_q <= '0;
            tol_q    <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
            run_q    <= run_d;
            target_q <= target_d;
            tol_q    <= tol_d;
            pass_q   <= pass_d;
        end
    end

    assign peak_load = (state_q == ST_STEP) && (cnt_q == '0);
    assign peak_en   = (state_q == ST_STEP);

    seq_peak_track #(
        .WIDTH (WIDTH)
    ) u_peak (
        .clk      (clk),
        .rst      (rst),
        .load     (peak_load),
        .en       (peak_en),
        .sample   (v_out),
        .peak_max (v_max),
        .peak_min (v_min)
    );

    // Pass is shown live during the check cycle so it is valid alongside done.
    always_comb begin
        v_in = ((state_q == ST_STEP) || (state_q == ST_CHECK)) ? STEP_VAL : '0;
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_CHECK);
        pass = (state_q == ST_CHECK) ? pass_now : pass_q;
    end

endmodule
